decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 65 ++++++
 rtl/decode_stage_imm_gen.sv | 22 ++
 rtl/decode_stage.sv | 137 +++++++++++++
 tb/tb_decode_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I opcodes, immediate formats, field widths
// and the registered decode payload layout.
package decode_pkg;

    localparam int XLEN     = 32;
    localparam int REG_W    = 5;
    localparam int OPC_W    = 7;
    localparam int FUNCT3_W = 3;
    localparam int FUNCT7_W = 7;

    localparam logic [OPC_W-1:0] OP_LUI     = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC   = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL     = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_JALR    = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_BRANCH  = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_LOAD    = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE   = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_OPIMM   = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_OP      = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_MISCMEM = 7'b0001111;
    localparam logic [OPC_W-1:0] OP_SYSTEM  = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } immFmt_e;

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     rs1Data;
        logic [XLEN-1:0]     rs2Data;
        logic [XLEN-1:0]     imm;
        logic [REG_W-1:0]    rd;
        logic [OPC_W-1:0]    opcode;
        logic [FUNCT3_W-1:0] funct3;
        logic [FUNCT7_W-1:0] funct7;
        logic                illegal;
    } decodePayload_t;

    // Immediate format of an opcode; unknown opcodes carry no immediate.
    function automatic immFmt_e immFmtOf(input logic [OPC_W-1:0] opc);
        case (opc)
            OP_OPIMM, OP_LOAD, OP_JALR, OP_SYSTEM: return FMT_I;
            OP_STORE:                              return FMT_S;
            OP_BRANCH:                             return FMT_B;
            OP_LUI, OP_AUIPC:                      return FMT_U;
            OP_JAL:                                return FMT_J;
            default:                               return FMT_NONE;
        endcase
    endfunction

    // True for the eleven RV32I base opcodes (all end in 2'b11).
    function automatic logic isLegalOpcode(input logic [OPC_W-1:0] opc);
        case (opc)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_OPIMM, OP_OP, OP_MISCMEM, OP_SYSTEM: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: sign-extended immediate per opcode format.
module imm_gen
    import decode_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] imm
);

    // Select and sign-extend the immediate bits for the instruction format.
    always_comb begin
        imm = '0;
        case (immFmtOf(instr[OPC_W-1:0]))
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'b0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: one-deep pipeline register between fetch and execute with
// writeback bypass, a single outstanding-load tracker and load-use hazard stall.
module decode_stage
    import decode_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                inValid,
    output logic                inReady,
    input  logic [XLEN-1:0]     inInstr,
    input  logic [XLEN-1:0]     inPc,
    output logic [REG_W-1:0]    cReg1Address,
    output logic [REG_W-1:0]    cReg2Address,
    input  logic [XLEN-1:0]     hReg1Data,
    input  logic [XLEN-1:0]     hReg2Data,
    input  logic [REG_W-1:0]    wbAddress,
    input  logic [XLEN-1:0]     wbData,
    input  logic                flush,
    output logic                outValid,
    input  logic                outReady,
    output logic [XLEN-1:0]     outPc,
    output logic [XLEN-1:0]     outRs1Data,
    output logic [XLEN-1:0]     outRs2Data,
    output logic [XLEN-1:0]     outImm,
    output logic [REG_W-1:0]    outRd,
    output logic [OPC_W-1:0]    outOpcode,
    output logic [FUNCT3_W-1:0] outFunct3,
    output logic [FUNCT7_W-1:0] outFunct7,
    output logic                outIllegal
);

    decodePayload_t   outReg;
    decodePayload_t   nextPayload;
    logic [XLEN-1:0]  immValue;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             pendValid;
    logic [REG_W-1:0] pendRd;
    logic             pendClear;
    logic             pendLive;
    logic             heldLoad;
    logic             rs1Hit;
    logic             rs2Hit;
    logic             loadHazard;
    logic             hazard;
    logic             capture;
    logic             loadLeaving;

    assign rs1          = inInstr[19:15];
    assign rs2          = inInstr[24:20];
    assign cReg1Address = rs1;
    assign cReg2Address = rs2;

    imm_gen uImmGen (
        .instr (inInstr),
        .imm   (immValue)
    );

    // A pending load whose writeback lands this cycle no longer blocks.
    assign pendClear   = pendValid && (wbAddress == pendRd);
    assign pendLive    = pendValid && !pendClear;
    // A load in the output register blocks even while it transfers: its data
    // only arrives later via writeback.
    assign heldLoad    = outValid && (outReg.opcode == OP_LOAD);
    assign loadLeaving = outValid && outReady && (outReg.opcode == OP_LOAD) && (outReg.rd != '0);

    assign rs1Hit     = (rs1 != '0) && ((pendLive && rs1 == pendRd) || (heldLoad && rs1 == outReg.rd));
    assign rs2Hit     = (rs2 != '0) && ((pendLive && rs2 == pendRd) || (heldLoad && rs2 == outReg.rd));
    assign loadHazard = (inInstr[OPC_W-1:0] == OP_LOAD) && (heldLoad || pendLive);
    assign hazard     = rs1Hit || rs2Hit || loadHazard;

    assign inReady = (!outValid || outReady) && !hazard && !flush;
    assign capture = inValid && inReady;

    // Assemble the payload, forwarding same-cycle writeback over the regfile read.
    always_comb begin
        nextPayload         = '0;
        nextPayload.pc      = inPc;
        nextPayload.imm     = immValue;
        nextPayload.rd      = inInstr[11:7];
        nextPayload.opcode  = inInstr[OPC_W-1:0];
        nextPayload.funct3  = inInstr[14:12];
        nextPayload.funct7  = inInstr[31:25];
        nextPayload.illegal = (inInstr[1:0] != 2'b11) || !isLegalOpcode(inInstr[OPC_W-1:0]);
        if (rs1 == '0)
            nextPayload.rs1Data = '0;
        else if (wbAddress == rs1)
            nextPayload.rs1Data = wbData;
        else
            nextPayload.rs1Data = hReg1Data;
        if (rs2 == '0)
            nextPayload.rs2Data = '0;
        else if (wbAddress == rs2)
            nextPayload.rs2Data = wbData;
        else
            nextPayload.rs2Data = hReg2Data;
    end

    // Output register: flush drops the held entry, capture loads, transfer empties.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            outValid <= 1'b0;
            outReg   <= '0;
        end else if (flush) begin
            outValid <= 1'b0;
        end else if (capture) begin
            outValid <= 1'b1;
            outReg   <= nextPayload;
        end else if (outReady) begin
            outValid <= 1'b0;
        end
    end

    // Load tracker: arm when a load leaves (flush or not), disarm on its writeback.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pendValid <= 1'b0;
            pendRd    <= '0;
        end else if (loadLeaving) begin
            pendValid <= 1'b1;
            pendRd    <= outReg.rd;
        end else if (pendClear) begin
            pendValid <= 1'b0;
        end
    end

    assign outPc      = outReg.pc;
    assign outRs1Data = outReg.rs1Data;
    assign outRs2Data = outReg.rs2Data;
    assign outImm     = outReg.imm;
    assign outRd      = outReg.rd;
    assign outOpcode  = outReg.opcode;
    assign outFunct3  = outReg.funct3;
    assign outFunct7  = outReg.funct7;
    assign outIllegal = outReg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: register-file model, scoreboard of expected payloads,
// one task per scenario.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [31:0] inInstr = '0;
    logic [31:0] inPc = '0;
    logic [4:0]  cReg1Address, cReg2Address;
    logic [31:0] hReg1Data, hReg2Data;
    logic [4:0]  wbAddress = '0;
    logic [31:0] wbData = '0;
    logic        flush = 1'b0;
    logic        outValid;
    logic        outReady = 1'b1;
    logic [31:0] outPc, outRs1Data, outRs2Data, outImm;
    logic [4:0]  outRd;
    logic [6:0]  outOpcode;
    logic [2:0]  outFunct3;
    logic [6:0]  outFunct7;
    logic        outIllegal;

    int nCmp = 0;
    int nErr = 0;
    logic [150:0] sb[$];
    logic [31:0]  rf[32];

    decode_stage dut (
        .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
        .inInstr(inInstr), .inPc(inPc), .cReg1Address(cReg1Address),
        .cReg2Address(cReg2Address), .hReg1Data(hReg1Data), .hReg2Data(hReg2Data),
        .wbAddress(wbAddress), .wbData(wbData), .flush(flush), .outValid(outValid),
        .outReady(outReady), .outPc(outPc), .outRs1Data(outRs1Data),
        .outRs2Data(outRs2Data), .outImm(outImm), .outRd(outRd), .outOpcode(outOpcode),
        .outFunct3(outFunct3), .outFunct7(outFunct7), .outIllegal(outIllegal)
    );

    always #5 clock = ~clock;

    // Register file model: known contents while in reset, written by writeback.
    assign hReg1Data = rf[cReg1Address];
    assign hReg2Data = rf[cReg2Address];
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= (i < 2) ? 32'h0 : 32'h2000 + i;
        end else if (wbAddress != 5'd0) begin
            rf[wbAddress] <= wbData;
        end
    end

    function automatic logic [31:0] refImm(input logic [31:0] i);
        case (i[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: refImm = 32'($signed(i) >>> 20);
            7'h23: refImm = {{20{i[31]}}, i[31:25], i[11:7]};
            7'h63: refImm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            7'h37, 7'h17: refImm = i & 32'hFFFFF000;
            7'h6F: refImm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            default: refImm = 32'h0;
        endcase
    endfunction

    function automatic logic refIllegal(input logic [31:0] i);
        case (i[6:0])
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
            7'h23, 7'h13, 7'h33, 7'h0F, 7'h73: refIllegal = 1'b0;
            default: refIllegal = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] refRead(input logic [4:0] a, input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) refRead = 32'h0;
        else if (wa == a) refRead = wd;
        else refRead = rf[a];
    endfunction

    function automatic logic [150:0] refPayload(input logic [31:0] i, input logic [31:0] pc,
                                                input logic [4:0] wa, input logic [31:0] wd);
        refPayload = {pc, refRead(i[19:15], wa, wd), refRead(i[24:20], wa, wd), refImm(i),
                      i[11:7], i[6:0], i[14:12], i[31:25], refIllegal(i)};
    endfunction

    // Scoreboard, run once per falling edge: compare held output against the
    // oldest expectation, retire it on transfer or flush, then enqueue a capture.
    task automatic step();
        logic [150:0] obs;
        @(negedge clock);
        if (!reset) begin
            sb.delete();
        end else begin
            if (outValid) begin
                obs = {outPc, outRs1Data, outRs2Data, outImm, outRd, outOpcode,
                       outFunct3, outFunct7, outIllegal};
                nCmp++;
                if (sb.size() == 0) begin
                    nErr++;
                    $display("FAIL sb_unexpected pc=%h got outValid=1 want no output", outPc);
                end else begin
                    if (obs !== sb[0]) begin
                        nErr++;
                        $display("FAIL sb_payload got %h want %h", obs, sb[0]);
                    end
                    if (outReady || flush) void'(sb.pop_front());
                end
            end
            if (inValid && inReady) sb.push_back(refPayload(inInstr, inPc, wbAddress, wbData));
        end
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        nCmp++; if (outValid !== 1'b0) begin nErr++; $display("FAIL reset_outValid got %b want 0", outValid); end
        nCmp++; if (inReady !== 1'b1) begin nErr++; $display("FAIL reset_inReady got %b want 1", inReady); end
        nCmp++; if ({outPc, outRs1Data, outRs2Data, outImm, outRd, outOpcode, outIllegal} !== '0) begin
            nErr++; $display("FAIL reset_payload got pc=%h imm=%h want 0", outPc, outImm); end
        nCmp++; if (dut.pendValid !== 1'b0) begin nErr++; $display("FAIL reset_pendValid got %b want 0", dut.pendValid); end
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        step(); adv();
    endtask

    task automatic test_addi();
        outReady = 1'b1; inValid = 1'b1; inInstr = 32'hFFF00293; inPc = 32'h100;
        step();
        nCmp++; if (inReady !== 1'b1) begin nErr++; $display("FAIL addi_inReady got %b want 1", inReady); end
        adv(); inValid = 1'b0;
        step();
        nCmp++; if (outValid !== 1'b1) begin nErr++; $display("FAIL addi_outValid got %b want 1", outValid); end
        nCmp++; if (outRd !== 5'd5) begin nErr++; $display("FAIL addi_outRd got %0d want 5", outRd); end
        nCmp++; if (outImm !== 32'hFFFFFFFF) begin nErr++; $display("FAIL addi_outImm got %h want ffffffff", outImm); end
        nCmp++; if (outIllegal !== 1'b0) begin nErr++; $display("FAIL addi_outIllegal got %b want 0", outIllegal); end
        adv();
    endtask

    task automatic test_bypass();
        inValid = 1'b1; inInstr = 32'h002081B3; inPc = 32'h104;
        wbAddress = 5'd1; wbData = 32'h1234;
        step(); adv();
        inValid = 1'b0; wbAddress = 5'd0;
        step();
        nCmp++; if (outRs1Data !== 32'h1234) begin nErr++; $display("FAIL bypass_rs1 got %h want 00001234", outRs1Data); end
        nCmp++; if (outRs2Data !== 32'h2002) begin nErr++; $display("FAIL bypass_rs2 got %h want 00002002", outRs2Data); end
        adv();
    endtask

    task automatic test_load_hazard();
        inValid = 1'b1; inInstr = 32'h0000A303; inPc = 32'h200;        // lw x6,0(x1)
        step();
        nCmp++; if (inReady !== 1'b1) begin nErr++; $display("FAIL lw_accept got %b want 1", inReady); end
        adv(); inInstr = 32'h00012483; inPc = 32'h204;                  // lw x9,0(x2)
        step();
        nCmp++; if (inReady !== 1'b0) begin nErr++; $display("FAIL lw_held_loadload got %b want 0", inReady); end
        adv();
        step();
        nCmp++; if (inReady !== 1'b0) begin nErr++; $display("FAIL lw_pend_loadload got %b want 0", inReady); end
        nCmp++; if (dut.pendValid !== 1'b1) begin nErr++; $display("FAIL lw_pendValid got %b want 1", dut.pendValid); end
        adv(); inInstr = 32'h006303B3; inPc = 32'h208;                  // add x7,x6,x6
        for (int c = 0; c < 2; c++) begin
            step();
            nCmp++; if (inReady !== 1'b0) begin nErr++; $display("FAIL lw_use_stall got %b want 0", inReady); end
            adv();
        end
        wbAddress = 5'd6; wbData = 32'hCAFEF00D;
        step();
        nCmp++; if (inReady !== 1'b1) begin nErr++; $display("FAIL lw_wb_release got %b want 1", inReady); end
        adv(); inValid = 1'b0; wbAddress = 5'd0;
        step();
        nCmp++; if (outRs1Data !== 32'hCAFEF00D || outRs2Data !== 32'hCAFEF00D) begin
            nErr++; $display("FAIL lw_use_bypass got %h/%h want cafef00d", outRs1Data, outRs2Data); end
        nCmp++; if (dut.pendValid !== 1'b0) begin nErr++; $display("FAIL lw_pend_cleared got %b want 0", dut.pendValid); end
        adv();
    endtask

    task automatic test_stall_flush();
        outReady = 1'b0; inValid = 1'b1; inInstr = 32'h7FF0C513; inPc = 32'h300;
        step(); adv();
        inInstr = 32'h0020A423; inPc = 32'h304;
        for (int c = 0; c < 3; c++) begin
            step();
            nCmp++; if (inReady !== 1'b0) begin nErr++; $display("FAIL stall_inReady got %b want 0", inReady); end
            nCmp++; if (outValid !== 1'b1 || outPc !== 32'h300 || outImm !== 32'h7FF) begin
                nErr++; $display("FAIL stall_hold got v=%b pc=%h imm=%h want 1/300/7ff", outValid, outPc, outImm); end
            adv();
        end
        flush = 1'b1;
        step();
        nCmp++; if (inReady !== 1'b0) begin nErr++; $display("FAIL flush_inReady got %b want 0", inReady); end
        adv(); flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        step();
        nCmp++; if (outValid !== 1'b0) begin nErr++; $display("FAIL flush_outValid got %b want 0", outValid); end
        adv();
    endtask

    task automatic test_illegal();
        inValid = 1'b1; inInstr = 32'h00000000; inPc = 32'h3F0;
        step(); adv(); inValid = 1'b0;
        step();
        nCmp++; if (outValid !== 1'b1 || outIllegal !== 1'b1) begin
            nErr++; $display("FAIL illegal_zero got v=%b ill=%b want 1/1", outValid, outIllegal); end
        nCmp++; if (outImm !== 32'h0) begin nErr++; $display("FAIL illegal_imm got %h want 0", outImm); end
        adv();
    endtask

    task automatic test_back_to_back();
        logic [31:0] prog[15];
        int waitCnt;
        prog = '{32'h00000000, 32'hFFFFFFFF, 32'h0020A423, 32'hFE208EE3, 32'h123452B7,
                 32'h00001317, 32'h0080006F, 32'hFF5FF06F, 32'h0000000F, 32'h00000073,
                 32'h00008067, 32'h40208033, 32'h12345678, 32'h00A0000B, 32'h00000290};
        for (int k = 0; k < 15; k++) begin
            inValid = 1'b1; inInstr = prog[k]; inPc = 32'h400 + 32'(4 * k);
            waitCnt = 0;
            forever begin
                outReady = ($urandom_range(0, 2) != 0);
                wbAddress = 5'($urandom_range(0, 31)); wbData = $urandom;
                step();
                if (inReady) begin adv(); break; end
                adv();
                waitCnt++;
                if (waitCnt > 20) begin
                    nCmp++; nErr++;
                    $display("FAIL b2b_timeout instr=%h got no accept want accept within 20 cycles", prog[k]);
                    break;
                end
            end
        end
        inValid = 1'b0; outReady = 1'b1; wbAddress = 5'd0;
        repeat (2) begin step(); adv(); end
        nCmp++; if (sb.size() != 0) begin nErr++; $display("FAIL b2b_drain got %0d left want 0", sb.size()); end
    endtask

    task automatic test_reset_midstall();
        outReady = 1'b1; inValid = 1'b1; inInstr = 32'h0000A303; inPc = 32'h500;
        step(); adv(); inValid = 1'b0;
        step(); adv();
        outReady = 1'b0; inValid = 1'b1; inInstr = 32'h00500593; inPc = 32'h504;
        step();
        nCmp++; if (inReady !== 1'b1) begin nErr++; $display("FAIL rst_pre_accept got %b want 1", inReady); end
        adv();
        step();
        nCmp++; if (outValid !== 1'b1 || dut.pendValid !== 1'b1) begin
            nErr++; $display("FAIL rst_pre_state got v=%b pend=%b want 1/1", outValid, dut.pendValid); end
        adv(); inValid = 1'b0;
        #2 reset = 1'b0;
        #1;
        nCmp++; if (outValid !== 1'b0) begin nErr++; $display("FAIL rst_mid_outValid got %b want 0", outValid); end
        nCmp++; if (dut.pendValid !== 1'b0 || dut.pendRd !== 5'd0) begin
            nErr++; $display("FAIL rst_mid_pend got %b/%0d want 0/0", dut.pendValid, dut.pendRd); end
        nCmp++; if ({outPc, outRd, outImm} !== '0) begin nErr++; $display("FAIL rst_mid_payload got pc=%h rd=%0d want 0", outPc, outRd); end
        nCmp++; if (inReady !== 1'b1) begin nErr++; $display("FAIL rst_mid_inReady got %b want 1", inReady); end
        sb.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1; outReady = 1'b1;
        inValid = 1'b1; inInstr = 32'h00500593; inPc = 32'h600;
        step();
        nCmp++; if (inReady !== 1'b1) begin nErr++; $display("FAIL rst_resume got %b want 1", inReady); end
        adv(); inValid = 1'b0;
        step(); adv();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_bypass();
        test_load_hazard();
        test_stall_flush();
        test_illegal();
        test_back_to_back();
        test_reset_midstall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish before 200000");
        $fatal(1);
    end

endmodule
